// File: rtl/trax_path_tracer_pkg.sv
// Shared Trax definitions: sides, tile codes, walk results and the colour/tile edge-pair table.
package trax_path_tracer_pkg;

  localparam logic [1:0] DirUp    = 2'd0;
  localparam logic [1:0] DirRight = 2'd1;
  localparam logic [1:0] DirDown  = 2'd2;
  localparam logic [1:0] DirLeft  = 2'd3;

  localparam logic [3:0] TileEmpty = 4'd0;
  localparam logic [3:0] TileLast  = 4'd6;

  typedef enum logic [2:0] {
    ResOpen    = 3'd0,
    ResLoop    = 3'd1,
    ResEdge    = 3'd2,
    ResLimit   = 3'd3,
    ResBadTile = 3'd4
  } result_e;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StStep,
    StDone
  } state_e;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
  } edge_pair_t;

  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'd2;
  endfunction

  // Sides joined by the tracked colour on tiles 1..6; other codes yield a dummy pair.
  function automatic edge_pair_t edge_pair(input logic white, input logic [3:0] tile);
    edge_pair_t p;
    p = '{a: DirUp, b: DirUp};
    case ({white, tile})
      {1'b1, 4'd1}: p = '{a: DirUp,    b: DirLeft};
      {1'b1, 4'd2}: p = '{a: DirRight, b: DirDown};
      {1'b1, 4'd3}: p = '{a: DirRight, b: DirLeft};
      {1'b1, 4'd4}: p = '{a: DirUp,    b: DirDown};
      {1'b1, 4'd5}: p = '{a: DirUp,    b: DirRight};
      {1'b1, 4'd6}: p = '{a: DirDown,  b: DirLeft};
      {1'b0, 4'd1}: p = '{a: DirRight, b: DirDown};
      {1'b0, 4'd2}: p = '{a: DirUp,    b: DirLeft};
      {1'b0, 4'd3}: p = '{a: DirUp,    b: DirDown};
      {1'b0, 4'd4}: p = '{a: DirRight, b: DirLeft};
      {1'b0, 4'd5}: p = '{a: DirDown,  b: DirLeft};
      {1'b0, 4'd6}: p = '{a: DirUp,    b: DirRight};
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/trax_path_tracer_if.sv
// Command/result and board-read signals of the path tracer.
interface trax_path_tracer_if #(
  parameter int unsigned CW = 3,
  parameter int unsigned SW = 7
);
  logic          start;
  logic [CW-1:0] start_row;
  logic [CW-1:0] start_col;
  logic [1:0]    start_parent;
  logic          track_white;
  logic          busy;
  logic          done;
  logic [2:0]    result;
  logic [SW-1:0] steps;
  logic          span_rows;
  logic          span_cols;
  logic          rd_req;
  logic [CW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic          rd_ack;
  logic [3:0]    rd_tile;

  modport master (
    input  start, start_row, start_col, start_parent, track_white, rd_ack, rd_tile,
    output busy, done, result, steps, span_rows, span_cols, rd_req, rd_row, rd_col
  );

  modport slave (
    output start, start_row, start_col, start_parent, track_white, rd_ack, rd_tile,
    input  busy, done, result, steps, span_rows, span_cols, rd_req, rd_row, rd_col
  );
endinterface

// File: rtl/trax_exit_lookup.sv
// Resolves the exit side of a tile for one colour given the entry side; valid=0 if not connected.
module trax_exit_lookup
  import trax_path_tracer_pkg::*;
(
  input  logic [3:0] tile,
  input  logic [1:0] parent,
  input  logic       white,
  output logic [1:0] exit_side,
  output logic       valid
);

  edge_pair_t pair;

  always_comb begin
    pair      = edge_pair(white, tile);
    exit_side = DirUp;
    valid     = 1'b0;
    if (tile != TileEmpty && tile <= TileLast) begin
      if (parent == pair.a) begin
        exit_side = pair.b;
        valid     = 1'b1;
      end else if (parent == pair.b) begin
        exit_side = pair.a;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trax_path_tracer.sv
// Walks one coloured line across the board, one tile read per step, and reports why it ended.
module trax_path_tracer
  import trax_path_tracer_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned CW        = 3,
  parameter int unsigned MAX_STEPS = 64,
  parameter int unsigned SW        = 7
) (
  input  logic               clk,
  input  logic               rst,
  trax_path_tracer_if.master bus
);

  localparam logic [CW-1:0] LastIdx   = CW'(N - 1);
  localparam logic [SW-1:0] StepLimit = SW'(MAX_STEPS);

  state_e        state_q;
  logic [CW-1:0] cur_row_q, cur_col_q, start_row_q, start_col_q;
  logic [1:0]    parent_q, start_parent_q;
  logic          white_q;
  logic [3:0]    tile_q;
  logic [SW-1:0] steps_q;
  result_e       result_q;
  logic          hit_top_q, hit_bot_q, hit_left_q, hit_right_q;
  logic          busy_q, done_q, rd_req_q;

  logic [1:0]    exit_side;
  logic          exit_valid;
  logic [SW-1:0] steps_inc;
  logic [CW-1:0] next_row, next_col;
  logic          leaves_board, closes_loop, step_finish;
  result_e       step_result;

  trax_exit_lookup u_exit_lookup (
    .tile      (tile_q),
    .parent    (parent_q),
    .white     (white_q),
    .exit_side (exit_side),
    .valid     (exit_valid)
  );

  always_comb begin
    steps_inc = steps_q + SW'(1);
    next_row  = cur_row_q;
    next_col  = cur_col_q;
    case (exit_side)
      DirUp:    next_row = cur_row_q - CW'(1);
      DirRight: next_col = cur_col_q + CW'(1);
      DirDown:  next_row = cur_row_q + CW'(1);
      DirLeft:  next_col = cur_col_q - CW'(1);
      default:  ;
    endcase
    // Checked before the neighbour is taken, so coordinates never wrap.
    leaves_board = (exit_side == DirUp    && cur_row_q == '0)     ||
                   (exit_side == DirRight && cur_col_q == LastIdx) ||
                   (exit_side == DirDown  && cur_row_q == LastIdx) ||
                   (exit_side == DirLeft  && cur_col_q == '0);
    closes_loop  = (next_row == start_row_q) && (next_col == start_col_q) &&
                   (opposite(exit_side) == start_parent_q);
    step_finish  = 1'b1;
    step_result  = ResOpen;
    if (tile_q == TileEmpty)        step_result = ResOpen;
    else if (!exit_valid)           step_result = ResBadTile;
    else if (leaves_board)          step_result = ResEdge;
    else if (closes_loop)           step_result = ResLoop;
    else if (steps_inc == StepLimit) step_result = ResLimit;
    else                            step_finish = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cur_row_q      <= '0;
      cur_col_q      <= '0;
      start_row_q    <= '0;
      start_col_q    <= '0;
      parent_q       <= '0;
      start_parent_q <= '0;
      white_q        <= 1'b0;
      tile_q         <= '0;
      steps_q        <= '0;
      result_q       <= ResOpen;
      hit_top_q      <= 1'b0;
      hit_bot_q      <= 1'b0;
      hit_left_q     <= 1'b0;
      hit_right_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      rd_req_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            start_row_q    <= bus.start_row;
            start_col_q    <= bus.start_col;
            start_parent_q <= bus.start_parent;
            cur_row_q      <= bus.start_row;
            cur_col_q      <= bus.start_col;
            parent_q       <= bus.start_parent;
            white_q        <= bus.track_white;
            steps_q        <= '0;
            hit_top_q      <= 1'b0;
            hit_bot_q      <= 1'b0;
            hit_left_q     <= 1'b0;
            hit_right_q    <= 1'b0;
            busy_q         <= 1'b1;
            rd_req_q       <= 1'b1;
            state_q        <= StFetch;
          end
        end
        StFetch: begin
          if (bus.rd_ack) begin
            tile_q   <= bus.rd_tile;
            rd_req_q <= 1'b0;
            state_q  <= StStep;
          end
        end
        StStep: begin
          if (exit_valid) begin
            steps_q     <= steps_inc;
            hit_top_q   <= hit_top_q   | (cur_row_q == '0);
            hit_bot_q   <= hit_bot_q   | (cur_row_q == LastIdx);
            hit_left_q  <= hit_left_q  | (cur_col_q == '0);
            hit_right_q <= hit_right_q | (cur_col_q == LastIdx);
          end
          if (step_finish) begin
            result_q <= step_result;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else begin
            cur_row_q <= next_row;
            cur_col_q <= next_col;
            parent_q  <= opposite(exit_side);
            rd_req_q  <= 1'b1;
            state_q   <= StFetch;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.steps     = steps_q;
  assign bus.span_rows = hit_top_q & hit_bot_q;
  assign bus.span_cols = hit_left_q & hit_right_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.rd_row    = cur_row_q;
  assign bus.rd_col    = cur_col_q;

endmodule

// File: tb/tb_trax_path_tracer.sv
// Self-checking bench: directed scenes from a table, random boards against a walk model.
module tb_trax_path_tracer;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] board [8][8];
  int         ack_delay = 0;
  int         wait_cnt  = 0;

  trax_path_tracer_if #(.CW(3), .SW(7)) tif ();

  trax_path_tracer #(.N(8), .CW(3), .MAX_STEPS(64), .SW(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Board store responder: acks after ack_delay waiting cycles (0 = same cycle).
  assign tif.rd_ack  = tif.rd_req && (wait_cnt == ack_delay);
  assign tif.rd_tile = board[tif.rd_row][tif.rd_col];

  always @(posedge clk) begin
    if (!tif.rd_req || tif.rd_ack) wait_cnt <= 0;
    else                           wait_cnt <= wait_cnt + 1;
  end

  // Colour/tile edge pairs, indexed by tile code.
  int wa [1:6] = '{0, 1, 1, 0, 0, 2};
  int wb [1:6] = '{3, 2, 3, 2, 1, 3};
  int ba [1:6] = '{1, 0, 0, 1, 2, 0};
  int bb [1:6] = '{2, 3, 2, 3, 3, 1};
  int dr [4]   = '{-1, 0, 1, 0};
  int dc [4]   = '{0, 1, 0, -1};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Address must hold while a read waits for its ack.
  logic       pend = 1'b0;
  logic [5:0] pend_addr;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend && tif.rd_req) check("addr_stable", int'({tif.rd_row, tif.rd_col}),
                                    int'(pend_addr));
      pend      = tif.rd_req && !tif.rd_ack;
      pend_addr = {tif.rd_row, tif.rd_col};
    end
  end

  function automatic int white_tile(input int a, input int b);
    for (int t = 1; t <= 6; t++)
      if ((wa[t] == a && wb[t] == b) || (wa[t] == b && wb[t] == a)) return t;
    return 0;
  endfunction

  // Reference walk straight from the tile rules.
  function automatic void model(input int r0, input int c0, input int p0, input bit w,
                                output int res, output int st, output bit sr, output bit sc);
    int r, c, p, t, a, b, e, nr, nc;
    bit t0, t7, l0, l7;
    r = r0; c = c0; p = p0; st = 0; res = -1;
    t0 = 0; t7 = 0; l0 = 0; l7 = 0;
    while (res < 0) begin
      t = int'(board[r][c]);
      if (t == 0) res = 0;
      else if (t > 6) res = 4;
      else begin
        a = w ? wa[t] : ba[t];
        b = w ? wb[t] : bb[t];
        e = (p == a) ? b : (p == b) ? a : -1;
        if (e < 0) res = 4;
        else begin
          st++;
          t0 |= (r == 0); t7 |= (r == 7); l0 |= (c == 0); l7 |= (c == 7);
          nr = r + dr[e];
          nc = c + dc[e];
          if (nr < 0 || nr > 7 || nc < 0 || nc > 7) res = 2;
          else if (nr == r0 && nc == c0 && (e ^ 2) == p0) res = 1;
          else if (st == 64) res = 3;
          else begin
            r = nr; c = nc; p = e ^ 2;
          end
        end
      end
    end
    sr = t0 && t7;
    sc = l0 && l7;
  endfunction

  task automatic clear_board();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) board[r][c] = 4'd0;
  endtask

  task automatic build_scene(input int s);
    int en, ex;
    clear_board();
    case (s)
      0: board[0][0] = 4'd4;
      1: begin
        board[0][0] = 4'd2; board[0][1] = 4'd6; board[1][1] = 4'd1; board[1][0] = 4'd5;
      end
      2: for (int r = 0; r < 8; r++) board[r][3] = 4'd4;
      3: board[0][0] = 4'd9;
      4: board[2][2] = 4'd1;
      5: for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          if (r % 2 == 0) begin
            en = (c == 0) ? ((r == 0) ? 3 : 0) : 3;
            ex = (c == 7) ? 2 : 1;
          end else begin
            en = (c == 7) ? 0 : 1;
            ex = (c == 0) ? ((r == 7) ? 0 : 2) : 3;
          end
          board[r][c] = 4'(white_tile(en, ex));
        end
      6: for (int r = 0; r < 8; r++) board[r][0] = 4'd3;
      7: board[3][7] = 4'd5;
      8: board[0][4] = 4'd4;
      default: ;
    endcase
  endtask

  // One walk; lat counts clock edges from the edge that samples start to the done edge.
  task automatic run(input int r, input int c, input int p, input bit w, input int dly,
                     input bit poke, input int exp_res, input int exp_st, input bit exp_sr,
                     input bit exp_sc);
    int lat, fetches;
    bit got;
    @(negedge clk);
    ack_delay        = dly;
    tif.start        = 1'b1;
    tif.start_row    = 3'(r);
    tif.start_col    = 3'(c);
    tif.start_parent = 2'(p);
    tif.track_white  = w;
    @(negedge clk);
    tif.start = 1'b0;
    check("busy_after_start", int'(tif.busy), 1);
    lat = 0;
    got = 1'b0;
    while (lat < 3000) begin
      if (tif.done) begin
        got = 1'b1;
        break;
      end
      if (poke && lat == 2) begin
        tif.start        = 1'b1;
        tif.start_row    = 3'(7 - r);
        tif.start_col    = 3'(7 - c);
        tif.start_parent = 2'(p + 1);
        tif.track_white  = ~w;
      end else begin
        tif.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    tif.start = 1'b0;
    check("done_seen", int'(got), 1);
    check("result", int'(tif.result), exp_res);
    check("steps", int'(tif.steps), exp_st);
    check("span_rows", int'(tif.span_rows), int'(exp_sr));
    check("span_cols", int'(tif.span_cols), int'(exp_sc));
    fetches = exp_st + ((exp_res == 0 || exp_res == 4) ? 1 : 0);
    check("latency", lat, fetches * (dly + 2));
    @(negedge clk);
    check("done_one_cycle", int'(tif.done), 0);
    check("idle_after_done", int'(tif.busy), 0);
  endtask

  typedef struct {
    int scene;
    int r, c, p;
    bit w;
    int dly;
    bit poke;
    int res, st;
    bit sr, sc;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int mres, mst, rr, cc, pp, dl, x, dcount;
    bit msr, msc, ww;

    vecs[0]  = '{0, 0, 0, 0, 1'b1, 0, 1'b0, 0, 1,  1'b0, 1'b0};
    vecs[1]  = '{1, 0, 0, 1, 1'b1, 0, 1'b0, 1, 4,  1'b0, 1'b0};
    vecs[2]  = '{2, 0, 3, 0, 1'b1, 0, 1'b0, 2, 8,  1'b1, 1'b0};
    vecs[3]  = '{2, 0, 3, 0, 1'b1, 3, 1'b1, 2, 8,  1'b1, 1'b0};
    vecs[4]  = '{2, 0, 3, 0, 1'b0, 1, 1'b0, 4, 0,  1'b0, 1'b0};
    vecs[5]  = '{3, 0, 0, 2, 1'b1, 0, 1'b0, 4, 0,  1'b0, 1'b0};
    vecs[6]  = '{4, 2, 2, 1, 1'b1, 2, 1'b0, 4, 0,  1'b0, 1'b0};
    vecs[7]  = '{5, 0, 0, 3, 1'b1, 0, 1'b0, 3, 64, 1'b1, 1'b1};
    vecs[8]  = '{6, 0, 0, 0, 1'b0, 1, 1'b0, 2, 8,  1'b1, 1'b0};
    vecs[9]  = '{7, 3, 7, 0, 1'b1, 0, 1'b0, 2, 1,  1'b0, 1'b0};
    vecs[10] = '{8, 0, 4, 2, 1'b1, 0, 1'b0, 2, 1,  1'b0, 1'b0};

    rst              = 1'b1;
    tif.start        = 1'b0;
    tif.start_row    = '0;
    tif.start_col    = '0;
    tif.start_parent = '0;
    tif.track_white  = 1'b0;
    clear_board();
    repeat (2) @(negedge clk);
    check("rst_busy", int'(tif.busy), 0);
    check("rst_done", int'(tif.done), 0);
    check("rst_result", int'(tif.result), 0);
    check("rst_steps", int'(tif.steps), 0);
    check("rst_span_rows", int'(tif.span_rows), 0);
    check("rst_span_cols", int'(tif.span_cols), 0);
    check("rst_rd_req", int'(tif.rd_req), 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      build_scene(vecs[i].scene);
      run(vecs[i].r, vecs[i].c, vecs[i].p, vecs[i].w, vecs[i].dly, vecs[i].poke,
          vecs[i].res, vecs[i].st, vecs[i].sr, vecs[i].sc);
    end

    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          x = int'($urandom_range(0, 19));
          if (x < 2)       board[r][c] = 4'd0;
          else if (x == 2) board[r][c] = 4'($urandom_range(7, 15));
          else             board[r][c] = 4'(1 + x % 6);
        end
      rr = int'($urandom_range(0, 7));
      cc = int'($urandom_range(0, 7));
      pp = int'($urandom_range(0, 3));
      ww = 1'($urandom_range(0, 1));
      dl = int'($urandom_range(0, 3));
      model(rr, cc, pp, ww, mres, mst, msr, msc);
      run(rr, cc, pp, ww, dl, 1'b0, mres, mst, msr, msc);
    end

    // Reset while a read is outstanding: outputs drop at once, walk abandoned.
    build_scene(2);
    @(negedge clk);
    ack_delay        = 6;
    tif.start        = 1'b1;
    tif.start_row    = 3'd0;
    tif.start_col    = 3'd3;
    tif.start_parent = 2'd0;
    tif.track_white  = 1'b1;
    @(negedge clk);
    tif.start = 1'b0;
    @(negedge clk);
    check("fetch_rd_req", int'(tif.rd_req), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_rd_req", int'(tif.rd_req), 0);
    check("midrst_busy", int'(tif.busy), 0);
    check("midrst_done", int'(tif.done), 0);
    check("midrst_steps", int'(tif.steps), 0);
    @(negedge clk);
    rst    = 1'b0;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (tif.done || tif.busy) dcount++;
    end
    check("no_done_after_rst", dcount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
